// File: rtl/match_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : match_controller_if
// Description : Button/goal inputs and scoreboard outputs of the match controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface match_controller_if;
    logic       start_btn;
    logic       blue_score_up;
    logic       red_score_up;
    logic       game_initiated;
    logic       game_over;
    logic [3:0] blue_score;
    logic [3:0] red_score;
    logic [7:0] time_left;
    logic [1:0] winner;

    modport master (
        output start_btn, blue_score_up, red_score_up,
        input  game_initiated, game_over, blue_score, red_score, time_left, winner
    );

    modport slave (
        input  start_btn, blue_score_up, red_score_up,
        output game_initiated, game_over, blue_score, red_score, time_left, winner
    );
endinterface
`default_nettype wire

// File: rtl/match_controller.sv
`default_nettype none
// ============================================================================
// Module      : match_controller
// Description : Match sequencing (serve, play, post-goal pause, game over),
//               score keeping, match clock and winner decision.
// Revision    : 1.0 - initial release
// ============================================================================
module match_controller #(
    parameter int TICK_DIV      = 25000000,
    parameter int MATCH_SECONDS = 90,
    parameter int WIN_SCORE     = 5,
    parameter int PAUSE_SECONDS = 2
) (
    input  wire logic           clk,
    input  wire logic           rst,
    match_controller_if.slave   bus
);

    localparam int c_TICK_W       = ($clog2(TICK_DIV) > 0) ? $clog2(TICK_DIV) : 1;
    localparam int c_PAUSE_CYCLES = PAUSE_SECONDS * TICK_DIV;
    localparam int c_PAUSE_W      = ($clog2(c_PAUSE_CYCLES) > 0) ? $clog2(c_PAUSE_CYCLES) : 1;

    localparam logic [c_TICK_W-1:0]  c_TICK_LAST  = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_PAUSE_W-1:0] c_PAUSE_LAST = c_PAUSE_W'(c_PAUSE_CYCLES - 1);
    localparam logic [7:0]           c_MATCH_TIME = 8'(MATCH_SECONDS);
    localparam logic [3:0]           c_WIN        = 4'(WIN_SCORE);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SERVE = 3'd1;
    localparam logic [2:0] c_ST_PLAY  = 3'd2;
    localparam logic [2:0] c_ST_PAUSE = 3'd3;
    localparam logic [2:0] c_ST_OVER  = 3'd4;

    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic                 r_start_prev;
    logic                 r_start_evt;
    logic                 r_blue_prev;
    logic                 r_red_prev;
    logic [3:0]           r_blue_score;
    logic [3:0]           r_red_score;
    logic [7:0]           r_time_left;
    logic [1:0]           r_winner;
    logic [c_TICK_W-1:0]  r_tick_cnt;
    logic [c_PAUSE_W-1:0] r_pause_cnt;

    logic       w_in_play;
    logic       w_blue_goal;
    logic       w_red_goal;
    logic       w_any_goal;
    logic [3:0] w_blue_next;
    logic [3:0] w_red_next;
    logic       w_blue_win;
    logic       w_red_win;
    logic       w_tick_wrap;
    logic [7:0] w_time_next;
    logic       w_game_initiated;
    logic       w_game_over;

    // Goals only count while the ball is live; edge registers track in every state.
    assign w_in_play   = (r_state == c_ST_PLAY);
    assign w_blue_goal = w_in_play && (bus.blue_score_up ^ r_blue_prev);
    assign w_red_goal  = w_in_play && (bus.red_score_up ^ r_red_prev);
    assign w_any_goal  = w_blue_goal || w_red_goal;
    assign w_blue_next = (w_blue_goal && (r_blue_score != 4'd15)) ? r_blue_score + 4'd1 : r_blue_score;
    assign w_red_next  = (w_red_goal && (r_red_score != 4'd15)) ? r_red_score + 4'd1 : r_red_score;
    assign w_blue_win  = w_blue_goal && (w_blue_next >= c_WIN);
    assign w_red_win   = w_red_goal && (w_red_next >= c_WIN);
    assign w_tick_wrap = (r_tick_cnt == c_TICK_LAST);
    assign w_time_next = (w_in_play && w_tick_wrap && (r_time_left != 8'd0)) ?
                         r_time_left - 8'd1 : r_time_left;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_OVER: begin
                if (r_start_evt) w_state_next = c_ST_SERVE;
            end
            c_ST_SERVE: w_state_next = c_ST_PLAY;
            c_ST_PLAY: begin
                if (w_blue_win || w_red_win)  w_state_next = c_ST_OVER;
                else if (w_any_goal)          w_state_next = c_ST_PAUSE;
                else if (w_time_next == 8'd0) w_state_next = c_ST_OVER;
            end
            c_ST_PAUSE: begin
                if (r_pause_cnt == c_PAUSE_LAST) w_state_next = c_ST_SERVE;
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_game_initiated = (r_state == c_ST_SERVE);
        w_game_over      = (r_state == c_ST_IDLE) || (r_state == c_ST_OVER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_prev <= bus.start_btn;
            r_blue_prev  <= bus.blue_score_up;
            r_red_prev   <= bus.red_score_up;
            r_start_evt  <= 1'b0;
            r_blue_score <= 4'd0;
            r_red_score  <= 4'd0;
            r_time_left  <= c_MATCH_TIME;
            r_winner     <= 2'd0;
            r_tick_cnt   <= '0;
            r_pause_cnt  <= '0;
        end else begin
            r_start_prev <= bus.start_btn;
            r_blue_prev  <= bus.blue_score_up;
            r_red_prev   <= bus.red_score_up;
            r_start_evt  <= bus.start_btn & ~r_start_prev;
            r_tick_cnt   <= '0;
            r_pause_cnt  <= '0;
            case (r_state)
                c_ST_IDLE, c_ST_OVER: begin
                    if (r_start_evt) begin
                        r_blue_score <= 4'd0;
                        r_red_score  <= 4'd0;
                        r_time_left  <= c_MATCH_TIME;
                        r_winner     <= 2'd0;
                    end
                end
                c_ST_PLAY: begin
                    r_blue_score <= w_blue_next;
                    r_red_score  <= w_red_next;
                    r_time_left  <= w_time_next;
                    r_tick_cnt   <= w_tick_wrap ? '0 : r_tick_cnt + 1'b1;
                    // Winner encoding doubles as {red, blue} flags, so a joint win reads as draw.
                    if (w_blue_win || w_red_win) begin
                        r_winner <= {w_red_win, w_blue_win};
                    end else if (!w_any_goal && (w_time_next == 8'd0)) begin
                        if (w_blue_next > w_red_next)      r_winner <= 2'd1;
                        else if (w_red_next > w_blue_next) r_winner <= 2'd2;
                        else                               r_winner <= 2'd3;
                    end
                end
                c_ST_PAUSE: r_pause_cnt <= r_pause_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.game_initiated = w_game_initiated;
    assign bus.game_over      = w_game_over;
    assign bus.blue_score     = r_blue_score;
    assign bus.red_score      = r_red_score;
    assign bus.time_left      = r_time_left;
    assign bus.winner         = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_match_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_match_controller
// Description : Directed scenarios with a queued scoreboard for match_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_match_controller;

    typedef struct {
        int         cyc;
        string      name;
        logic       gi;
        logic       go;
        logic [3:0] b;
        logic [3:0] r;
        logic [7:0] t;
        logic [1:0] w;
    } snap_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    snap_t q_snap[$];
    int    q_serve[$];
    logic  done;

    match_controller_if bus();

    match_controller #(
        .TICK_DIV      (10),
        .MATCH_SECONDS (5),
        .WIN_SCORE     (3),
        .PAUSE_SECONDS (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void snap(input int off, input string name, input logic gi, input logic go,
                                 input logic [3:0] b, input logic [3:0] r,
                                 input logic [7:0] t, input logic [1:0] w);
        snap_t s;
        s.cyc = cyc + off; s.name = name; s.gi = gi; s.go = go;
        s.b = b; s.r = r; s.t = t; s.w = w;
        q_snap.push_back(s);
    endfunction

    function automatic void serve(input int off);
        q_serve.push_back(cyc + off);
    endfunction

    // Monitor: compare whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        if (!done) begin
            checks++;
            if (bus.game_initiated && bus.game_over) begin
                errors++;
                $display("FAIL excl cyc=%0d game_initiated and game_over both high", cyc);
            end
            if (bus.game_initiated) begin
                checks++;
                if (q_serve.size() == 0 || q_serve[0] != cyc) begin
                    errors++;
                    $display("FAIL serve_pulse got cyc=%0d expected cyc=%0d", cyc,
                             (q_serve.size() == 0) ? -1 : q_serve[0]);
                end
                if (q_serve.size() != 0 && q_serve[0] <= cyc) void'(q_serve.pop_front());
            end
            for (int i = q_snap.size() - 1; i >= 0; i--) begin
                if (q_snap[i].cyc == cyc) begin
                    checks++;
                    if (bus.game_initiated !== q_snap[i].gi || bus.game_over !== q_snap[i].go ||
                        bus.blue_score !== q_snap[i].b || bus.red_score !== q_snap[i].r ||
                        bus.time_left !== q_snap[i].t || bus.winner !== q_snap[i].w) begin
                        errors++;
                        $display("FAIL %s cyc=%0d got gi=%0d go=%0d b=%0d r=%0d t=%0d w=%0d exp gi=%0d go=%0d b=%0d r=%0d t=%0d w=%0d",
                                 q_snap[i].name, cyc, bus.game_initiated, bus.game_over,
                                 bus.blue_score, bus.red_score, bus.time_left, bus.winner,
                                 q_snap[i].gi, q_snap[i].go, q_snap[i].b, q_snap[i].r,
                                 q_snap[i].t, q_snap[i].w);
                    end
                    q_snap.delete(i);
                end
            end
        end
    end

    initial begin
        checks = 0; errors = 0; done = 1'b0;
        rst = 1'b1;
        bus.start_btn = 1'b0; bus.blue_score_up = 1'b0; bus.red_score_up = 1'b0;
        step(3);
        snap(0, "reset", 0, 1, 0, 0, 5, 0);
        rst = 1'b0;
        step(2);

        // Held start gives one serve; blue goal, pause, re-serve.
        bus.start_btn = 1'b1;
        serve(2);
        snap(2, "serve1", 1, 0, 0, 0, 5, 0);
        snap(3, "play1", 0, 0, 0, 0, 5, 0);
        step(20);
        bus.start_btn = 1'b0;
        bus.blue_score_up = ~bus.blue_score_up;
        snap(1, "blue_goal", 0, 0, 1, 0, 4, 0);
        snap(10, "pause_end", 0, 0, 1, 0, 4, 0);
        serve(11);
        snap(12, "replay", 0, 0, 1, 0, 4, 0);
        step(12);

        // Start ignored mid-play, then reset during a pause with simultaneous goals.
        bus.start_btn = 1'b1;
        step(1);
        bus.start_btn = 1'b0;
        step(3);
        bus.red_score_up = ~bus.red_score_up;
        snap(1, "red_goal", 0, 0, 1, 1, 4, 0);
        step(4);
        rst = 1'b1;
        bus.blue_score_up = ~bus.blue_score_up;
        bus.red_score_up = ~bus.red_score_up;
        snap(1, "rst_pause", 0, 1, 0, 0, 5, 0);
        step(1);
        rst = 1'b0;
        snap(15, "rst_quiet", 0, 1, 0, 0, 5, 0);
        step(15);

        // Three joint goals reach the win score together.
        bus.start_btn = 1'b1;
        serve(2);
        snap(2, "serve2", 1, 0, 0, 0, 5, 0);
        step(3);
        bus.start_btn = 1'b0;
        bus.blue_score_up = ~bus.blue_score_up; bus.red_score_up = ~bus.red_score_up;
        snap(1, "tie1", 0, 0, 1, 1, 5, 0);
        serve(11);
        step(12);
        bus.blue_score_up = ~bus.blue_score_up; bus.red_score_up = ~bus.red_score_up;
        snap(1, "tie2", 0, 0, 2, 2, 5, 0);
        serve(11);
        step(12);
        bus.blue_score_up = ~bus.blue_score_up; bus.red_score_up = ~bus.red_score_up;
        snap(1, "both_win", 0, 1, 3, 3, 5, 3);
        step(1);
        bus.blue_score_up = ~bus.blue_score_up;
        snap(2, "over_hold", 0, 1, 3, 3, 5, 3);
        step(2);

        // Goalless match runs the clock out to a draw.
        bus.start_btn = 1'b1;
        serve(2);
        snap(2, "serve3", 1, 0, 0, 0, 5, 0);
        step(3);
        bus.start_btn = 1'b0;
        snap(10, "sec1", 0, 0, 0, 0, 4, 0);
        snap(49, "last_sec", 0, 0, 0, 0, 1, 0);
        snap(50, "timeout_draw", 0, 1, 0, 0, 0, 3);
        step(50);
        bus.blue_score_up = ~bus.blue_score_up; bus.red_score_up = ~bus.red_score_up;
        snap(3, "over_ignore", 0, 1, 0, 0, 0, 3);
        step(3);

        // Red leads at timeout, then a restart clears everything.
        bus.start_btn = 1'b1;
        serve(2);
        snap(2, "serve4", 1, 0, 0, 0, 5, 0);
        step(3);
        bus.start_btn = 1'b0;
        bus.red_score_up = ~bus.red_score_up;
        snap(1, "red_lead", 0, 0, 0, 1, 5, 0);
        serve(11);
        step(12);
        snap(50, "red_wins", 0, 1, 0, 1, 0, 2);
        step(50);
        bus.start_btn = 1'b1;
        serve(2);
        snap(2, "restart", 1, 0, 0, 0, 5, 0);
        step(3);
        bus.start_btn = 1'b0;
        step(2);

        done = 1'b1;
        foreach (q_serve[i]) begin
            checks++; errors++;
            $display("FAIL serve_missing got none expected cyc=%0d", q_serve[i]);
        end
        foreach (q_snap[i]) begin
            checks++; errors++;
            $display("FAIL %s_missing got none expected cyc=%0d", q_snap[i].name, q_snap[i].cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
